// File: rtl/median_window_3x3_if.sv
// Pixel stream in / 3x3 window out bundle for the median window builder.
// The master side drives the raster stream and observes the window; the
// slave side is the window builder itself.
interface median_window_3x3_if #(
  parameter int COLOR_DEPTH = 8
) ();
  localparam int PW = 3 * COLOR_DEPTH;

  logic              vs_in;
  logic              de_in;
  logic [PW-1:0]     data_in;
  logic              vs_out;
  logic              de_out;
  logic              win_valid;
  logic [9*PW-1:0]   win_data;

  modport master (
    output vs_in, de_in, data_in,
    input  vs_out, de_out, win_valid, win_data
  );

  modport slave (
    input  vs_in, de_in, data_in,
    output vs_out, de_out, win_valid, win_data
  );
endinterface

// File: rtl/median_window_3x3.sv
// 3x3 neighbourhood builder for the median filter. Two line buffers hold
// the previous line and the line before it; a 3x3 shift window collects
// {two-lines-back, previous-line, current} column vectors. Missing rows at
// the top of a frame and missing columns at the left of a line read as 0.
// Tap k = r*3+c sits at win_data[k*PW +: PW]; r=0 oldest row, c=2 newest.
// The interface COLOR_DEPTH must match this module's COLOR_DEPTH.
module median_window_3x3 #(
  parameter int COLOR_DEPTH = 8,
  parameter int MAX_H       = 1920,
  parameter int ADDR_W      = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  median_window_3x3_if.slave   bus
);
  localparam int PW    = 3 * COLOR_DEPTH;
  localparam int LB_AW = (MAX_H > 1) ? $clog2(MAX_H) : 1;
  localparam logic [ADDR_W-1:0] MAX_COL = ADDR_W'(MAX_H);

  // Line buffers: LB0 = previous line, LB1 = two lines back.
  logic [PW-1:0] lb0 [MAX_H];
  logic [PW-1:0] lb1 [MAX_H];
  logic [PW-1:0] rd0_q, rd1_q;

  // Counters.
  logic [ADDR_W-1:0] col_cnt_q, col_cnt_d;
  logic [1:0]        row_cnt_q, row_cnt_d;

  // Stage 1 registers.
  logic              vs_d1_q, de_d1_q;
  logic [PW-1:0]     data_d1_q;
  logic [ADDR_W-1:0] col_d1_q;
  logic              row_ge1_q, row_ge2_q;

  // Stage 2 registers.
  logic              vs_d2_q, de_d2_q;
  logic [PW-1:0]     win_q [3][3];

  logic              rd_en, wr_en, col_ok_d1;
  logic [PW-1:0]     up0, up1;

  assign rd_en     = bus.de_in && (col_cnt_q < MAX_COL);
  assign col_ok_d1 = col_d1_q < MAX_COL;
  assign wr_en     = de_d1_q && col_ok_d1;

  // Next-state for column (saturating, cleared outside de) and row counters.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    col_cnt_d = '0;
    row_cnt_d = row_cnt_q;
    if (bus.de_in) begin
      col_cnt_d = (col_cnt_q == MAX_COL) ? col_cnt_q : col_cnt_q + ADDR_W'(1);
    end
    if (bus.vs_in && !vs_d1_q) begin
      row_cnt_d = '0;
    end else if (de_d1_q && !bus.de_in && (row_cnt_q != 2'd2)) begin
      row_cnt_d = row_cnt_q + 2'd1;
    end
  end

  // Line buffer read (stage 0) and write-back of the shifted rows (stage 1).
  always_ff @(posedge clk) begin
    // NOTE: the line buffers are deliberately not reset; row masking hides stale data.
    if (rd_en) begin
      rd0_q <= lb0[col_cnt_q[LB_AW-1:0]];
      rd1_q <= lb1[col_cnt_q[LB_AW-1:0]];
    end
    if (wr_en) begin
      lb0[col_d1_q[LB_AW-1:0]] <= data_d1_q;
      lb1[col_d1_q[LB_AW-1:0]] <= rd0_q;
    end
  end

  // Counters, stage-1 pipeline and output control delay.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      vs_d1_q   <= 1'b0;
      de_d1_q   <= 1'b0;
      data_d1_q <= '0;
      col_d1_q  <= '0;
      row_ge1_q <= 1'b0;
      row_ge2_q <= 1'b0;
      vs_d2_q   <= 1'b0;
      de_d2_q   <= 1'b0;
    end else begin
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      vs_d1_q   <= bus.vs_in;
      de_d1_q   <= bus.de_in;
      data_d1_q <= bus.data_in;
      col_d1_q  <= col_cnt_q;
      row_ge1_q <= (row_cnt_q != 2'd0);
      row_ge2_q <= (row_cnt_q == 2'd2);
      vs_d2_q   <= vs_d1_q;
      de_d2_q   <= de_d1_q;
    end
  end

  // Upper rows are masked at the top of a frame and beyond the buffer depth.
  assign up1 = (row_ge1_q && col_ok_d1) ? rd0_q : '0;
  assign up0 = (row_ge2_q && col_ok_d1) ? rd1_q : '0;

  // Window shift: new column enters on the right; left border zero-padded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (de_d1_q) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= (col_d1_q == '0) ? '0 : win_q[r][1];
        win_q[r][1] <= (col_d1_q == '0) ? '0 : win_q[r][2];
      end
      win_q[0][2] <= up0;
      win_q[1][2] <= up1;
      win_q[2][2] <= data_d1_q;
    end
  end

  // Flatten the window into tap order k = r*3+c.
  always_comb begin
    bus.win_data = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        bus.win_data[(r*3+c)*PW +: PW] = win_q[r][c];
      end
    end
  end

  assign bus.vs_out    = vs_d2_q;
  assign bus.de_out    = de_d2_q;
  assign bus.win_valid = de_d2_q;
endmodule

// File: tb/tb_median_window_3x3.sv
// Bench for median_window_3x3 with a shallow line buffer (MAX_H=4) so
// over-wide lines are easy to exercise. The driver computes expected windows
// from a per-column history model and queues them; a negedge monitor pops
// and compares whenever the DUT presents a window.
module tb_median_window_3x3;
  localparam int CD     = 8;
  localparam int PW     = 3 * CD;
  localparam int WW     = 9 * PW;
  localparam int MAX_H  = 4;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  median_window_3x3_if #(.COLOR_DEPTH(CD)) bus ();

  median_window_3x3 #(.COLOR_DEPTH(CD), .MAX_H(MAX_H), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [WW-1:0] win;
    bit            has_lit;
    logic [WW-1:0] mask;
    logic [WW-1:0] lit;
    string         name;
  } exp_t;

  typedef struct {
    int at;
    bit vs;
    bit de;
    bit zero;
  } ctrl_t;

  exp_t  wq[$];
  ctrl_t cq[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  // Reference model state.
  int               m_row, m_col;
  bit               m_de_prev, m_vs_prev;
  logic [PW-1:0]    hist1 [MAX_H];
  logic [PW-1:0]    hist2 [MAX_H];
  logic [3*PW-1:0]  line_q[$];   // column vectors of the current line, row r at [r*PW]
  bit               zero_flag;
  bit               lit_armed;
  logic [WW-1:0]    lit_mask, lit_val;
  string            lit_name;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] tap(int k, logic [PW-1:0] v);
    logic [WW-1:0] t;
    t = '0;
    t[k*PW +: PW] = v;
    return t;
  endfunction

  function automatic logic [PW-1:0] px_rc(int r, int c);
    logic [7:0] b;
    b = 8'(r * 16 + c);
    return {b, b, b};
  endfunction

  function automatic logic [PW-1:0] pl(int id, int c);
    return {8'(id), 8'(c), 8'hC3};
  endfunction

  // Window = last three column vectors of the current line, zeros where absent.
  function automatic logic [WW-1:0] model_window();
    logic [WW-1:0]   w;
    logic [3*PW-1:0] v;
    int              idx;
    w = '0;
    for (int c = 0; c < 3; c++) begin
      idx = line_q.size() - 3 + c;
      v = (idx >= 0) ? line_q[idx] : '0;
      for (int r = 0; r < 3; r++) w[(r*3+c)*PW +: PW] = v[r*PW +: PW];
    end
    return w;
  endfunction

  task automatic arm(string nm, logic [WW-1:0] mask, logic [WW-1:0] lit);
    lit_armed = 1'b1;
    lit_name  = nm;
    lit_mask  = mask;
    lit_val   = lit;
  endtask

  // Apply one cycle of input, update the model, queue expectations.
  task automatic step(bit r, bit v, bit d, logic [PW-1:0] px);
    ctrl_t         c;
    exp_t          e;
    logic [PW-1:0] up0, up1;
    rst         = r;
    bus.vs_in   = v;
    bus.de_in   = d;
    bus.data_in = px;
    c.at   = cyc + 1;
    c.vs   = r ? 1'b0 : v;
    c.de   = r ? 1'b0 : d;
    c.zero = zero_flag;
    cq.push_back(c);
    if (r) begin
      m_row = 0; m_col = 0; m_de_prev = 1'b0; m_vs_prev = 1'b0;
      line_q.delete();
    end else begin
      if (d) begin
        up0 = '0;
        up1 = '0;
        if (m_col < MAX_H) begin
          if (m_row >= 1) up1 = hist1[m_col];
          if (m_row >= 2) up0 = hist2[m_col];
          hist2[m_col] = hist1[m_col];
          hist1[m_col] = px;
        end
        if (m_col == 0) line_q.delete();
        line_q.push_back({px, up1, up0});
        e.win     = model_window();
        e.has_lit = lit_armed;
        e.mask    = lit_mask;
        e.lit     = lit_val;
        e.name    = lit_name;
        lit_armed = 1'b0;
        wq.push_back(e);
      end
      if (v && !m_vs_prev)                    m_row = 0;
      else if (m_de_prev && !d && m_row < 2)  m_row = m_row + 1;
      m_col     = d ? ((m_col < MAX_H) ? m_col + 1 : MAX_H) : 0;
      m_de_prev = d;
      m_vs_prev = v;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: control delay every cycle, window whenever win_valid.
  ctrl_t mc;
  exp_t  me;
  always @(negedge clk) begin
    if (cq.size() > 0 && cq[0].at + 1 == cyc) begin
      mc = cq.pop_front();
      check("vs_out", WW'(bus.vs_out), WW'(mc.vs));
      check("de_out", WW'(bus.de_out), WW'(mc.de));
      check("win_valid", WW'(bus.win_valid), WW'(mc.de));
      if (mc.zero) check("reset_win", bus.win_data, '0);
    end
    if (bus.win_valid) begin
      if (wq.size() == 0) begin
        check("win_unexpected", WW'(bus.win_valid), '0);
      end else begin
        me = wq.pop_front();
        check("window", bus.win_data, me.win);
        if (me.has_lit) check(me.name, bus.win_data & me.mask, me.lit);
      end
    end
  end

  initial begin
    logic [WW-1:0] lit;
    int            nl, len, vsat;
    for (int i = 0; i < MAX_H; i++) begin
      hist1[i] = '0;
      hist2[i] = '0;
    end
    m_row = 0; m_col = 0; m_de_prev = 1'b0; m_vs_prev = 1'b0;
    lit_armed = 1'b0; lit_mask = '0; lit_val = '0; lit_name = "";

    // Reset held 3 clocks with live-looking input, then 2 quiet clocks.
    zero_flag = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
    idle(2);
    zero_flag = 1'b0;

    // Line 0 of a frame: only row-2 taps carry data.
    step(1'b0, 1'b1, 1'b0, '0);
    idle(1);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) arm("line0_taps", '1, tap(6, 24'h020202) | tap(7, 24'h030303) | tap(8, 24'h040404));
      step(1'b0, 1'b0, 1'b1, PW'(c * 24'h010101));
    end
    idle(2);

    // 4x3 frame, pixel = row*16+col per channel.
    step(1'b0, 1'b1, 1'b0, '0);
    idle(1);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r == 2 && c == 0)
          arm("left_border", '1, tap(5, px_rc(1, 0)) | tap(8, px_rc(2, 0)));
        if (r == 2 && c == 2) begin
          lit = '0;
          for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++) lit |= tap(rr*3+cc, px_rc(rr, cc));
          arm("row2_col2", '1, lit);
        end
        step(1'b0, 1'b0, 1'b1, px_rc(r, c));
      end
      idle(1);
    end
    idle(1);

    // Two lines, reset mid-frame, then a new line without vs.
    step(1'b0, 1'b1, 1'b0, '0);
    idle(1);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b1, pl(8'h11, c));
    idle(1);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b1, pl(8'h12, c));
    idle(2);
    step(1'b1, 1'b0, 1'b0, '0);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) arm("post_reset_row0", '1, tap(7, pl(8'h13, 0)) | tap(8, pl(8'h13, 1)));
      step(1'b0, 1'b0, 1'b1, pl(8'h13, c));
    end
    idle(1);

    // Lines wider than the buffer: columns past MAX_H have no upper rows.
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 1'b1, pl(8'h14, c));
    idle(1);
    for (int c = 0; c < 6; c++) begin
      if (c == 3) arm("wide_col3_up", tap(2, '1) | tap(5, '1), tap(2, pl(8'h13, 3)) | tap(5, pl(8'h14, 3)));
      if (c == 4) arm("wide_col4_up", tap(2, '1) | tap(5, '1), '0);
      if (c == 5) arm("wide_col5_up", tap(1, '1) | tap(2, '1) | tap(4, '1) | tap(5, '1), '0);
      step(1'b0, 1'b0, 1'b1, pl(8'h15, c));
    end
    idle(1);

    // Randomised frames: varied widths, gaps, and occasional vs inside de.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < int'($urandom_range(1, 2)); i++) step(1'b0, 1'b1, 1'b0, '0);
      idle(int'($urandom_range(1, 3)));
      nl = int'($urandom_range(2, 5));
      for (int l = 0; l < nl; l++) begin
        len  = int'($urandom_range(1, 6));
        vsat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : len;
        for (int c = 0; c < len; c++) step(1'b0, c >= vsat, 1'b1, PW'($urandom));
        idle(int'($urandom_range(1, 3)));
      end
    end

    idle(4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("drain", WW'(wq.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
